id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register of the P5 five-stage CPU; sits directly upstream of the execute-stage ALU.
- Captures decoded operands and control each cycle and presents the ALU source operands and ALU control as registered outputs.
- Supports stall (hold) and flush (bubble) from the hazard unit.
- Refreshes held operands with write-back data, so a stalled instruction never executes with stale register values.

---
 rtl/id_ex_stage_reg.sv | 100 ++++++++++
 tb/tb_id_ex_stage_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands/control, holds on stall,
// bubbles on flush, and keeps held operands coherent with write-back.
module id_ex_stage_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          valid_D_i,
    input  logic [RW-1:0] rs_D_i,
    input  logic [RW-1:0] rt_D_i,
    input  logic [RW-1:0] rd_D_i,
    input  logic [DW-1:0] rs_data_D_i,
    input  logic [DW-1:0] rt_data_D_i,
    input  logic [DW-1:0] imm_ext_D_i,
    input  logic [DW-1:0] pc8_D_i,
    input  logic [2:0]    ALU_ctrl_D_i,
    input  logic          ALU_src_D_i,
    input  logic          reg_dst_D_i,
    input  logic          reg_write_D_i,
    input  logic          mem_write_D_i,
    input  logic          mem_to_reg_D_i,
    input  logic          wb_we_W_i,
    input  logic [RW-1:0] wb_addr_W_i,
    input  logic [DW-1:0] wb_data_W_i,
    output logic          valid_E_o,
    output logic [DW-1:0] ALU_srca_E_o,
    output logic [DW-1:0] ALU_srcb_E_o,
    output logic [2:0]    ALU_ctrl_E_o,
    output logic [DW-1:0] rt_data_E_o,
    output logic [RW-1:0] rs_E_o,
    output logic [RW-1:0] rt_E_o,
    output logic [RW-1:0] write_addr_E_o,
    output logic          reg_write_E_o,
    output logic          mem_write_E_o,
    output logic          mem_to_reg_E_o,
    output logic [DW-1:0] pc8_E_o
);

    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic          alu_src_q;
    logic [RW-1:0] dst_D;
    logic          wen_D, wb_hit, byp_rs, byp_rt, ref_rs, ref_rt, bubble;

    always_comb begin
        dst_D  = reg_dst_D_i ? rd_D_i : rt_D_i;
        wen_D  = reg_write_D_i && (dst_D != '0);
        // Register 0 is hardwired, so a write-back to it never bypasses.
        wb_hit = wb_we_W_i && (wb_addr_W_i != '0);
        byp_rs = wb_hit && (wb_addr_W_i == rs_D_i);
        byp_rt = wb_hit && (wb_addr_W_i == rt_D_i);
        ref_rs = wb_hit && (wb_addr_W_i == rs_E_o);
        ref_rt = wb_hit && (wb_addr_W_i == rt_E_o);
        // Flush beats stall; an invalid decode slot loads as a bubble.
        bubble = reset || flush_i || (!stall_i && !valid_D_i);
    end

    always_ff @(posedge clk) begin
        if (bubble) begin
            valid_E_o      <= 1'b0;
            rs_data_q      <= '0;
            rt_data_q      <= '0;
            imm_q          <= '0;
            alu_src_q      <= 1'b0;
            ALU_ctrl_E_o   <= 3'b000;
            rs_E_o         <= '0;
            rt_E_o         <= '0;
            write_addr_E_o <= '0;
            reg_write_E_o  <= 1'b0;
            mem_write_E_o  <= 1'b0;
            mem_to_reg_E_o <= 1'b0;
            pc8_E_o        <= '0;
        end else if (stall_i) begin
            // Held instruction must see results retiring while it waits.
            if (ref_rs) rs_data_q <= wb_data_W_i;
            if (ref_rt) rt_data_q <= wb_data_W_i;
        end else begin
            valid_E_o      <= 1'b1;
            rs_data_q      <= byp_rs ? wb_data_W_i : rs_data_D_i;
            rt_data_q      <= byp_rt ? wb_data_W_i : rt_data_D_i;
            imm_q          <= imm_ext_D_i;
            alu_src_q      <= ALU_src_D_i;
            ALU_ctrl_E_o   <= ALU_ctrl_D_i;
            rs_E_o         <= rs_D_i;
            rt_E_o         <= rt_D_i;
            write_addr_E_o <= wen_D ? dst_D : '0;
            reg_write_E_o  <= wen_D;
            mem_write_E_o  <= mem_write_D_i;
            mem_to_reg_E_o <= mem_to_reg_D_i;
            pc8_E_o        <= pc8_D_i;
        end
    end

    assign ALU_srca_E_o = rs_data_q;
    assign ALU_srcb_E_o = alu_src_q ? imm_q : rt_data_q;
    assign rt_data_E_o  = rt_data_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Table-driven bench for id_ex_stage_reg: each row is one clock edge of
// stimulus plus the expected E-stage outputs after that edge.
module tb_id_ex_stage_reg;

    logic        clk = 0;
    logic        reset, stall_i, flush_i, valid_D_i;
    logic [4:0]  rs_D_i, rt_D_i, rd_D_i, wb_addr_W_i;
    logic [31:0] rs_data_D_i, rt_data_D_i, imm_ext_D_i, pc8_D_i, wb_data_W_i;
    logic [2:0]  ALU_ctrl_D_i;
    logic        ALU_src_D_i, reg_dst_D_i, reg_write_D_i, mem_write_D_i, mem_to_reg_D_i, wb_we_W_i;
    logic        valid_E_o, reg_write_E_o, mem_write_E_o, mem_to_reg_E_o;
    logic [31:0] ALU_srca_E_o, ALU_srcb_E_o, rt_data_E_o, pc8_E_o;
    logic [2:0]  ALU_ctrl_E_o;
    logic [4:0]  rs_E_o, rt_E_o, write_addr_E_o;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_D_i(valid_D_i),
        .rs_D_i(rs_D_i), .rt_D_i(rt_D_i), .rd_D_i(rd_D_i),
        .rs_data_D_i(rs_data_D_i), .rt_data_D_i(rt_data_D_i), .imm_ext_D_i(imm_ext_D_i),
        .pc8_D_i(pc8_D_i), .ALU_ctrl_D_i(ALU_ctrl_D_i), .ALU_src_D_i(ALU_src_D_i),
        .reg_dst_D_i(reg_dst_D_i), .reg_write_D_i(reg_write_D_i), .mem_write_D_i(mem_write_D_i),
        .mem_to_reg_D_i(mem_to_reg_D_i), .wb_we_W_i(wb_we_W_i), .wb_addr_W_i(wb_addr_W_i),
        .wb_data_W_i(wb_data_W_i), .valid_E_o(valid_E_o), .ALU_srca_E_o(ALU_srca_E_o),
        .ALU_srcb_E_o(ALU_srcb_E_o), .ALU_ctrl_E_o(ALU_ctrl_E_o), .rt_data_E_o(rt_data_E_o),
        .rs_E_o(rs_E_o), .rt_E_o(rt_E_o), .write_addr_E_o(write_addr_E_o),
        .reg_write_E_o(reg_write_E_o), .mem_write_E_o(mem_write_E_o),
        .mem_to_reg_E_o(mem_to_reg_E_o), .pc8_E_o(pc8_E_o)
    );

    typedef struct packed {
        logic        rst, stall, flush, vld;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm, pc8;
        logic [2:0]  ctrl;
        logic        src, dst, rw, mw, mtr, wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        e_vld;
        logic [31:0] e_srca, e_srcb, e_rtd, e_pc8;
        logic [2:0]  e_ctrl;
        logic [4:0]  e_rs, e_rt, e_wa;
        logic        e_rw, e_mw, e_mtr;
    } vec_t;

    vec_t tbl [32];
    int   n = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; stall_i = v.stall; flush_i = v.flush; valid_D_i = v.vld;
        rs_D_i = v.rs; rt_D_i = v.rt; rd_D_i = v.rd;
        rs_data_D_i = v.rs_data; rt_data_D_i = v.rt_data; imm_ext_D_i = v.imm; pc8_D_i = v.pc8;
        ALU_ctrl_D_i = v.ctrl; ALU_src_D_i = v.src; reg_dst_D_i = v.dst; reg_write_D_i = v.rw;
        mem_write_D_i = v.mw; mem_to_reg_D_i = v.mtr;
        wb_we_W_i = v.wb_we; wb_addr_W_i = v.wb_addr; wb_data_W_i = v.wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input vec_t v, input int row);
        chk("valid", row, {31'b0, valid_E_o}, {31'b0, v.e_vld});
        chk("srca", row, ALU_srca_E_o, v.e_srca);
        chk("srcb", row, ALU_srcb_E_o, v.e_srcb);
        chk("rt_data", row, rt_data_E_o, v.e_rtd);
        chk("pc8", row, pc8_E_o, v.e_pc8);
        chk("ctrl", row, {29'b0, ALU_ctrl_E_o}, {29'b0, v.e_ctrl});
        chk("rs_E", row, {27'b0, rs_E_o}, {27'b0, v.e_rs});
        chk("rt_E", row, {27'b0, rt_E_o}, {27'b0, v.e_rt});
        chk("write_addr", row, {27'b0, write_addr_E_o}, {27'b0, v.e_wa});
        chk("reg_write", row, {31'b0, reg_write_E_o}, {31'b0, v.e_rw});
        chk("mem_write", row, {31'b0, mem_write_E_o}, {31'b0, v.e_mw});
        chk("mem_to_reg", row, {31'b0, mem_to_reg_E_o}, {31'b0, v.e_mtr});
    endtask

    vec_t v;
    localparam int STALL_ROW = 11;

    initial begin
        // 0: reset, everything zero
        v = '0; v.rst = 1; tbl[n++] = v;
        // 1: load rs_data 0x1234
        v = '0; v.vld = 1; v.rs = 1; v.rt = 2; v.rd = 3; v.rs_data = 32'h1234; v.rt_data = 32'h22;
        v.imm = 32'h10; v.pc8 = 32'h108; v.ctrl = 3'b001; v.dst = 1; v.rw = 1;
        v.e_vld = 1; v.e_srca = 32'h1234; v.e_srcb = 32'h22; v.e_rtd = 32'h22; v.e_pc8 = 32'h108;
        v.e_ctrl = 3'b001; v.e_rs = 1; v.e_rt = 2; v.e_wa = 3; v.e_rw = 1; tbl[n++] = v;
        // 2: reset while stalling clears everything
        v = '0; v.rst = 1; v.stall = 1; v.vld = 1; v.rs = 4; v.rs_data = 32'h77; tbl[n++] = v;
        // 3: basic load, srcb = immediate
        v = '0; v.vld = 1; v.rs = 4; v.rt = 6; v.rs_data = 5; v.rt_data = 7; v.imm = 32'h10;
        v.src = 1; v.ctrl = 3'b010; v.rw = 1; v.pc8 = 32'h20;
        v.e_vld = 1; v.e_srca = 5; v.e_srcb = 32'h10; v.e_rtd = 7; v.e_pc8 = 32'h20;
        v.e_ctrl = 3'b010; v.e_rs = 4; v.e_rt = 6; v.e_wa = 6; v.e_rw = 1; tbl[n++] = v;
        // 4: srcb = rt data, store without register write
        v.src = 0; v.rw = 0; v.mw = 1; v.e_srcb = 7; v.e_wa = 0; v.e_rw = 0; v.e_mw = 1; tbl[n++] = v;
        // 5: load-time bypass of rs
        v = '0; v.vld = 1; v.rs = 8; v.rt = 9; v.rs_data = 32'hAAAA; v.rt_data = 32'h99; v.rw = 1;
        v.mtr = 1; v.ctrl = 3'b100; v.pc8 = 32'h30; v.wb_we = 1; v.wb_addr = 8; v.wb_data = 32'h5555;
        v.e_vld = 1; v.e_srca = 32'h5555; v.e_srcb = 32'h99; v.e_rtd = 32'h99; v.e_pc8 = 32'h30;
        v.e_ctrl = 3'b100; v.e_rs = 8; v.e_rt = 9; v.e_wa = 9; v.e_rw = 1; v.e_mtr = 1; tbl[n++] = v;
        // 6: write-back to r0 does not bypass
        v.wb_addr = 0; v.e_srca = 32'hAAAA; tbl[n++] = v;
        // 7: bypass of both rs and rt from the same write-back
        v = '0; v.vld = 1; v.rs = 3; v.rt = 3; v.rd = 5; v.rs_data = 1; v.rt_data = 2; v.dst = 1;
        v.rw = 1; v.ctrl = 3'b110; v.pc8 = 32'h40; v.wb_we = 1; v.wb_addr = 3; v.wb_data = 32'h77;
        v.e_vld = 1; v.e_srca = 32'h77; v.e_srcb = 32'h77; v.e_rtd = 32'h77; v.e_pc8 = 32'h40;
        v.e_ctrl = 3'b110; v.e_rs = 3; v.e_rt = 3; v.e_wa = 5; v.e_rw = 1; tbl[n++] = v;
        // 8: load that will be stalled
        v = '0; v.vld = 1; v.rs = 1; v.rt = 3; v.rd = 4; v.rs_data = 32'h11; v.rt_data = 32'h33;
        v.imm = 32'h44; v.ctrl = 3'b011; v.dst = 1; v.rw = 1; v.pc8 = 32'h50;
        v.e_vld = 1; v.e_srca = 32'h11; v.e_srcb = 32'h33; v.e_rtd = 32'h33; v.e_pc8 = 32'h50;
        v.e_ctrl = 3'b011; v.e_rs = 1; v.e_rt = 3; v.e_wa = 4; v.e_rw = 1; tbl[n++] = v;
        // 9: stall, write-back to held rt refreshes rt data only
        v.stall = 1; v.rs = 20; v.rt = 21; v.rd = 22; v.rs_data = 32'hDEAD; v.rt_data = 32'hDEAD;
        v.imm = 32'hDEAD; v.pc8 = 32'hDEAD; v.ctrl = 3'b111; v.src = 1; v.mw = 1; v.mtr = 1;
        v.wb_we = 1; v.wb_addr = 3; v.wb_data = 32'hBEEF;
        v.e_srcb = 32'hBEEF; v.e_rtd = 32'hBEEF; tbl[n++] = v;
        // 10: stall, write-back to held rs
        v.wb_addr = 1; v.wb_data = 32'hCAFE; v.e_srca = 32'hCAFE; tbl[n++] = v;
        // 11: stall, write-back disabled leaves state alone
        v.wb_we = 0; v.wb_data = 32'h9999; tbl[n++] = v;
        // 12: flush with stall -> bubble
        v = '0; v.stall = 1; v.flush = 1; v.vld = 1; v.rs = 7; v.rs_data = 32'h70; v.rw = 1; v.rt = 7;
        tbl[n++] = v;
        // 13: next cycle loads new inputs
        v = '0; v.vld = 1; v.rs = 7; v.rt = 8; v.rd = 9; v.rs_data = 32'h70; v.rt_data = 32'h80;
        v.imm = 32'h90; v.src = 1; v.ctrl = 3'b101; v.dst = 1; v.rw = 1; v.pc8 = 32'h200;
        v.e_vld = 1; v.e_srca = 32'h70; v.e_srcb = 32'h90; v.e_rtd = 32'h80; v.e_pc8 = 32'h200;
        v.e_ctrl = 3'b101; v.e_rs = 7; v.e_rt = 8; v.e_wa = 9; v.e_rw = 1; tbl[n++] = v;
        // 14: reg_dst=1, rd=0 -> no write
        v = '0; v.vld = 1; v.rs = 1; v.rt = 2; v.rd = 0; v.rs_data = 1; v.rt_data = 2; v.dst = 1; v.rw = 1;
        v.e_vld = 1; v.e_srca = 1; v.e_srcb = 2; v.e_rtd = 2; v.e_rs = 1; v.e_rt = 2; tbl[n++] = v;
        // 15: reg_dst=0, rt=9; rs=r0 with write-back to r0 is not bypassed
        v = '0; v.vld = 1; v.rs = 0; v.rt = 9; v.rs_data = 32'h12; v.rt_data = 3; v.rw = 1;
        v.wb_we = 1; v.wb_addr = 0; v.wb_data = 32'hFF;
        v.e_vld = 1; v.e_srca = 32'h12; v.e_srcb = 3; v.e_rtd = 3; v.e_rt = 9; v.e_wa = 9; v.e_rw = 1;
        tbl[n++] = v;
        // 16: valid_D=0 captures a bubble
        v = '0; v.vld = 0; v.rs = 5; v.rt = 6; v.rd = 7; v.rs_data = 32'h55; v.rt_data = 32'h66;
        v.imm = 32'h1; v.src = 1; v.ctrl = 3'b010; v.dst = 1; v.rw = 1; v.mw = 1; v.mtr = 1;
        v.pc8 = 32'h300; tbl[n++] = v;

        for (int i = 0; i < n; i++) begin
            apply(tbl[i]);
            check_out(tbl[i], i);
            if (i == STALL_ROW) begin
                // Stall held, D inputs churning, unrelated write-back: no change for 4 cycles.
                for (int k = 0; k < 4; k++) begin
                    v = tbl[STALL_ROW];
                    v.rs_data = $urandom; v.rt_data = $urandom; v.imm = $urandom; v.pc8 = $urandom;
                    v.rs = 5'(10 + k); v.rt = 5'(12 + k); v.rd = 5'(14 + k);
                    v.wb_we = 1; v.wb_addr = 5; v.wb_data = $urandom;
                    apply(v);
                    check_out(v, 100 + k);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
